// File: rtl/regfile_2r1w.sv
// Register file with one write port and two registered read ports with write-to-read bypass.
// Optional macro REGFILE_R0_ZERO_EN hardwires register 0 to zero.
module regfile_2r1w #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   write,
    input  logic [ADDR_W-1:0]      writenum,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   ren_a,
    input  logic [ADDR_W-1:0]      readnum_a,
    input  logic                   ren_b,
    input  logic [ADDR_W-1:0]      readnum_b,
    output logic [DATA_W-1:0]      data_out_a,
    output logic [DATA_W-1:0]      data_out_b,
    output logic                   valid_a,
    output logic                   valid_b,
    output logic [2**ADDR_W-1:0]   wr_mask
);

    localparam int NREG = 2**ADDR_W;

`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    logic [DATA_W-1:0] regs [NREG];
    logic              wr_en;
    logic [DATA_W-1:0] rd_a_next;
    logic [DATA_W-1:0] rd_b_next;

    // With R0_ZERO, writes to register 0 are dropped here, so register 0 stays 0
    // and the bypass below can never forward data_in to a read of address 0.
    always_comb begin
        wr_en = write && !(R0_ZERO && (writenum == '0));
    end

    always_comb begin
        rd_a_next = regs[readnum_a];
        rd_b_next = regs[readnum_b];
        if (wr_en && (writenum == readnum_a)) rd_a_next = data_in;
        if (wr_en && (writenum == readnum_b)) rd_b_next = data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the storage array is reset deliberately, because every register
            // must read back 0 after reset; this rules out inferring a RAM macro.
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            data_out_a <= '0;
            data_out_b <= '0;
            valid_a    <= 1'b0;
            valid_b    <= 1'b0;
            wr_mask    <= '0;
        end else begin
            // NOTE: non-blocking assignments, so the read muxes see pre-edge register
            // contents and the bypass alone supplies same-cycle write data.
            if (wr_en) begin
                regs[writenum]    <= data_in;
                wr_mask[writenum] <= 1'b1;
            end
            valid_a <= ren_a;
            valid_b <= ren_b;
            if (ren_a) data_out_a <= rd_a_next;
            if (ren_b) data_out_b <= rd_b_next;
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: directed test-plan sequences followed by random traffic
// checked against a behavioural array model.
module tb_regfile_2r1w;

    localparam int DW   = 16;
    localparam int AW   = 3;
    localparam int NREG = 2**AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          write = 1'b0;
    logic [AW-1:0] writenum = '0;
    logic [DW-1:0] data_in = '0;
    logic          ren_a = 1'b0;
    logic [AW-1:0] readnum_a = '0;
    logic          ren_b = 1'b0;
    logic [AW-1:0] readnum_b = '0;
    logic [DW-1:0] data_out_a, data_out_b;
    logic          valid_a, valid_b;
    logic [NREG-1:0] wr_mask;

    regfile_2r1w #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .write(write), .writenum(writenum), .data_in(data_in),
        .ren_a(ren_a), .readnum_a(readnum_a), .ren_b(ren_b), .readnum_b(readnum_b),
        .data_out_a(data_out_a), .data_out_b(data_out_b),
        .valid_a(valid_a), .valid_b(valid_b), .wr_mask(wr_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            rst;
        bit            va;
        bit            vb;
        bit [NREG-1:0] mask;
    } ctl_t;

    ctl_t          ctl_q[$];
    logic [DW-1:0] da_q[$];
    logic [DW-1:0] db_q[$];

    int checks   = 0;
    int failures = 0;

`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    // Reference model: plain array plus mask
    logic [DW-1:0] mem [NREG];
    bit   [NREG-1:0] mask_m = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] addr, input bit w,
                                                 input logic [AW-1:0] wn, input logic [DW-1:0] d);
        if (R0_ZERO && addr == 0) return '0;
        if (w && wn == addr) return d;
        return mem[addr];
    endfunction

    task automatic step(input bit rst, input bit w, input logic [AW-1:0] wn, input logic [DW-1:0] d,
                        input bit ra, input logic [AW-1:0] na, input bit rb, input logic [AW-1:0] nb);
        ctl_t c;
        reset = rst; write = w; writenum = wn; data_in = d;
        ren_a = ra; readnum_a = na; ren_b = rb; readnum_b = nb;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem[i] = '0;
            mask_m = '0;
            c = '{rst: 1'b1, va: 1'b0, vb: 1'b0, mask: '0};
        end else begin
            if (ra) da_q.push_back(model_read(na, w, wn, d));
            if (rb) db_q.push_back(model_read(nb, w, wn, d));
            if (w && !(R0_ZERO && wn == 0)) begin
                mem[wn] = d;
                mask_m[wn] = 1'b1;
            end
            c = '{rst: 1'b0, va: ra, vb: rb, mask: mask_m};
        end
        ctl_q.push_back(c);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: pops expectations on the falling edge, independent of stimulus
    logic [DW-1:0] hold_a = '0;
    logic [DW-1:0] hold_b = '0;

    initial begin
        ctl_t c;
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (ctl_q.size() > 0) begin
                c = ctl_q.pop_front();
                if (c.rst) begin
                    hold_a = '0;
                    hold_b = '0;
                end
                check("valid_a", 32'(valid_a), 32'(c.va));
                check("valid_b", 32'(valid_b), 32'(c.vb));
                check("wr_mask", 32'(wr_mask), 32'(c.mask));
                if (valid_a === 1'b1) begin
                    if (da_q.size() == 0) check("port_a_unexpected_valid", 32'(1), 32'(0));
                    else begin
                        e = da_q.pop_front();
                        check("data_out_a", 32'(data_out_a), 32'(e));
                        hold_a = e;
                    end
                end else begin
                    check("data_out_a_hold", 32'(data_out_a), 32'(hold_a));
                end
                if (valid_b === 1'b1) begin
                    if (db_q.size() == 0) check("port_b_unexpected_valid", 32'(1), 32'(0));
                    else begin
                        e = db_q.pop_front();
                        check("data_out_b", 32'(data_out_b), 32'(e));
                        hold_b = e;
                    end
                end else begin
                    check("data_out_b_hold", 32'(data_out_b), 32'(hold_b));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NREG; i++) mem[i] = '0;
        @(posedge clk); #1;

        // TP1: basic write then dual read
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 3, 16'h1234, 0, 0, 0, 0);
        step(0, 1, 5, 16'hBEEF, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 3, 1, 5);
        check("tp1_data_a", 32'(data_out_a), 32'h1234);
        check("tp1_data_b", 32'(data_out_b), 32'hBEEF);
        check("tp1_valid", 32'({valid_a, valid_b}), 32'b11);
        check("tp1_mask", 32'(wr_mask), 32'b0010_1000);

        // TP2: same-cycle bypass
        step(0, 1, 2, 16'h0001, 0, 0, 0, 0);
        step(0, 1, 2, 16'hA5A5, 1, 2, 0, 0);
        check("tp2_bypass", 32'(data_out_a), 32'hA5A5);
        idle();
        step(0, 0, 0, 0, 1, 2, 0, 0);
        check("tp2_reread", 32'(data_out_a), 32'hA5A5);

        // TP3: hold while idle, with a write to the read register
        step(0, 0, 0, 0, 1, 3, 0, 0);
        check("tp3_first", 32'(data_out_a), 32'h1234);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 3, 16'h9999, 0, 0, 0, 0);
            check("tp3_hold_data", 32'(data_out_a), 32'h1234);
            check("tp3_hold_valid", 32'(valid_a), 32'(0));
        end

        // TP4: reset mid-operation beats write and read
        for (int i = 0; i < NREG; i++) step(0, 1, AW'(i), DW'(16'h1000 + i), 0, 0, 0, 0);
        check("tp4_mask_full", 32'(wr_mask), R0_ZERO ? 32'hFE : 32'hFF);
        step(1, 1, 7, 16'h7777, 1, 7, 1, 7);
        check("tp4_rst_outputs", 32'({data_out_a, data_out_b, valid_a, valid_b, wr_mask}), 32'(0));
        step(0, 0, 0, 0, 1, 7, 0, 0);
        check("tp4_r7_cleared", 32'(data_out_a), 32'h0000);

        // TP5: both ports on one address
        step(0, 1, 6, 16'h0F0F, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 6, 1, 6);
        check("tp5_a", 32'(data_out_a), 32'h0F0F);
        check("tp5_b", 32'(data_out_b), 32'h0F0F);

        // TP6: register 0 behaviour
        step(0, 1, 0, 16'hFFFF, 1, 0, 0, 0);
        check("tp6_r0_read", 32'(data_out_a), R0_ZERO ? 32'h0000 : 32'hFFFF);
        check("tp6_r0_mask", 32'(wr_mask[0]), R0_ZERO ? 32'(0) : 32'(1));

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, AW'($urandom),
                 DW'($urandom), $urandom_range(0, 2) != 0, AW'($urandom),
                 $urandom_range(0, 2) != 0, AW'($urandom));
        end

        idle();
        idle();
        @(negedge clk);
        @(negedge clk);
        check("queues_drained", 32'(ctl_q.size() + da_q.size() + db_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
